// File: rtl/hazard_scoreboard.sv
// Issue sequencer between ID and EXE: tracks the EX/MEM destinations, raises RAW stalls,
// squashes issue on taken branches and keeps saturating stall/flush counters.
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             freeze,
    output logic             hazard,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_v;
    logic             ex_wb;
    logic             ex_mr;
    logic [REG_W-1:0] ex_dest;
    logic             mem_v;
    logic             mem_wb;
    logic [REG_W-1:0] mem_dest;

    logic ex_hit;
    logic mem_hit;
    logic issue;

    // A slot only matters when it holds a valid register writer; src2 is ignored unless used.
    always_comb begin
        ex_hit  = ex_v & ex_wb &
                  ((ex_dest == id_src1) | (id_two_src & (ex_dest == id_src2)));
        mem_hit = mem_v & mem_wb &
                  ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
    end

    // With forwarding only a load still in EX cannot supply its result in time.
    always_comb begin
        if (fwd_en) begin
            hazard = id_valid & ex_mr & ex_hit;
        end else begin
            hazard = id_valid & (ex_hit | mem_hit);
        end
        flush = branch_taken;
        issue = id_valid & ~hazard & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v     <= 1'b0;
            ex_wb    <= 1'b0;
            ex_mr    <= 1'b0;
            ex_dest  <= '0;
            mem_v    <= 1'b0;
            mem_wb   <= 1'b0;
            mem_dest <= '0;
        end else if (!freeze) begin
            mem_v    <= ex_v;
            mem_wb   <= ex_wb;
            mem_dest <= ex_dest;
            if (issue) begin
                ex_v    <= 1'b1;
                ex_wb   <= id_wb_en;
                ex_mr   <= id_mem_r_en;
                ex_dest <= id_dest;
            end else begin
                ex_v    <= 1'b0;
                ex_wb   <= 1'b0;
                ex_mr   <= 1'b0;
                ex_dest <= '0;
            end
        end
    end

    // Counters stick at all-ones so long runs never alias back to small values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!freeze) begin
            if (hazard && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stalls in both modes, branch squash, freeze,
// counter saturation (wide and narrow instance) and asynchronous reset.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        fwd_en;
    logic        branch_taken;
    logic        freeze;
    logic        hazard;
    logic        flush;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic        hazard_s;
    logic        flush_s;
    logic [1:0]  stall_count_s;
    logic [1:0]  flush_count_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
        .freeze(freeze), .hazard(hazard), .flush(flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_scoreboard #(.REG_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
        .freeze(freeze), .hazard(hazard_s), .flush(flush_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    // Advance one clock; inputs change and outputs are sampled 1-3 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic [3:0] d, input logic wb,
                          input logic mr);
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_two_src  = two;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = mr;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fwd_en = 1'($urandom_range(0, 1));
        branch_taken = 1'b0;
        freeze = 1'($urandom_range(0, 1));
        set_id(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1,
               4'($urandom_range(0, 15)), 1'b1, 1'($urandom_range(0, 1)));
        tick();
        #2;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %0b want 0", hazard); end
        checks++;
        if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %0b want 0", flush); end
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", stall_count, flush_count);
        end
        tick();
        rst = 1'b1;
        freeze = 1'b0;
        fwd_en = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL idle_hazard: got %0b want 0", hazard); end
        tick();
    endtask

    task automatic test_full_stall();
        fwd_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL fs_producer: got %0b want 0", hazard); end
        tick();
        set_id(1'b1, 4'd3, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL fs_stall_ex: got %0b want 1", hazard); end
        tick();
        #2;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL fs_stall_mem: got %0b want 1", hazard); end
        tick();
        #2;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL fs_issue: got %0b want 0", hazard); end
        checks++;
        if (stall_count !== 16'd2) begin errors++; $display("[TB] FAIL fs_count: got %0d want 2", stall_count); end
        tick();
        idle(2);
    endtask

    task automatic test_forwarding();
        fwd_en = 1'b1;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL fw_load_use: got %0b want 1", hazard); end
        tick();
        #2;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL fw_mem_free: got %0b want 0", hazard); end
        tick();
        idle(2);
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL fw_alu: got %0b want 0", hazard); end
        tick();
        idle(2);
        checks++;
        if (stall_count !== 16'd3) begin errors++; $display("[TB] FAIL fw_count: got %0d want 3", stall_count); end
    endtask

    task automatic test_operand_masking();
        fwd_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd1, 4'd6, 1'b0, 4'd7, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL mask_src2: got %0b want 0", hazard); end
        tick();
        idle(2);
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'd8, 4'd8, 1'b1, 4'd8, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL nowb_ex: got %0b want 0", hazard); end
        tick();
        set_id(1'b1, 4'd8, 4'd1, 1'b0, 4'd9, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL nowb_mem: got %0b want 0", hazard); end
        tick();
        idle(2);
    endtask

    task automatic test_branch_flush();
        fwd_en = 1'b0;
        branch_taken = 1'b1;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0);
        checks++;
        if (flush !== 1'b1 || hazard !== 1'b0) begin
            errors++; $display("[TB] FAIL br_flush: got flush=%0b hazard=%0b want 1/0", flush, hazard);
        end
        tick();
        branch_taken = 1'b0;
        set_id(1'b1, 4'd9, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL br_bubble: got %0b want 0", hazard); end
        checks++;
        if (flush_count !== 16'd1) begin errors++; $display("[TB] FAIL br_count: got %0d want 1", flush_count); end
        idle(2);
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd10, 1'b1, 1'b0);
        tick();
        branch_taken = 1'b1;
        set_id(1'b1, 4'd10, 4'd2, 1'b1, 4'd11, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b1 || flush !== 1'b1) begin
            errors++; $display("[TB] FAIL both_out: got hazard=%0b flush=%0b want 1/1", hazard, flush);
        end
        tick();
        branch_taken = 1'b0;
        set_id(1'b1, 4'd11, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL both_bubble: got %0b want 0", hazard); end
        checks++;
        if (stall_count !== 16'd4 || flush_count !== 16'd2) begin
            errors++; $display("[TB] FAIL both_count: got %0d/%0d want 4/2", stall_count, flush_count);
        end
        idle(2);
    endtask

    task automatic test_freeze();
        fwd_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd12, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd3, 4'd12, 1'b1, 4'd13, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            checks++;
            if (hazard !== 1'b1 || stall_count !== 16'd4) begin
                errors++; $display("[TB] FAIL frz_hold%0d: got hazard=%0b stall=%0d want 1/4", i, hazard, stall_count);
            end
        end
        freeze = 1'b0;
        tick();
        #2;
        checks++;
        if (hazard !== 1'b1 || stall_count !== 16'd5) begin
            errors++; $display("[TB] FAIL frz_resume: got hazard=%0b stall=%0d want 1/5", hazard, stall_count);
        end
        tick();
        #2;
        checks++;
        if (hazard !== 1'b0 || stall_count !== 16'd6) begin
            errors++; $display("[TB] FAIL frz_issue: got hazard=%0b stall=%0d want 0/6", hazard, stall_count);
        end
        checks++;
        if (stall_count_s !== 2'd3) begin errors++; $display("[TB] FAIL sat_small_stall: got %0d want 3", stall_count_s); end
        tick();
        idle(2);
    endtask

    task automatic test_saturation();
        branch_taken = 1'b1;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 65532; i++) tick();
        checks++;
        if (flush_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_near: got %0h want fffe", flush_count); end
        tick();
        checks++;
        if (flush_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_top: got %0h want ffff", flush_count); end
        tick();
        tick();
        checks++;
        if (flush_count !== 16'hFFFF || flush_count_s !== 2'd3) begin
            errors++; $display("[TB] FAIL sat_stick: got %0h/%0d want ffff/3", flush_count, flush_count_s);
        end
        branch_taken = 1'b0;
        idle(2);
    endtask

    task automatic test_async_reset();
        fwd_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd13, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd13, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got %0b want 1", hazard); end
        rst = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++; $display("[TB] FAIL ar_clear: got hazard=%0b counts=%0d/%0d want 0/0/0", hazard, stall_count, flush_count);
        end
        tick();
        rst = 1'b1;
        tick();
        #2;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL ar_after: got %0b want 0", hazard); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_stall();
        test_forwarding();
        test_operand_masking();
        test_branch_flush();
        test_freeze();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
